// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - fetch_state_t : fetch FSM state encodings (2-bit, one spare code)
//   - INSTR_W        : width of one fetched instruction (halfword)
//   - HALFWORD_BYTES : PC increment between consecutive instructions
package instruction_fetch_pkg;

    localparam int INSTR_W        = 16;
    localparam int HALFWORD_BYTES = 2;

    typedef enum logic [1:0] {
        ST_ISSUE     = 2'b00,   // request may be raised
        ST_WAIT_DATA = 2'b01,   // read accepted, waiting for data to push
        ST_DISCARD   = 2'b10    // read accepted before a branch, data dropped
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions and their addresses.
// Ports:
//   clk, reset (async, active-low)
//   push, push_instr, push_pc : write one entry
//   pop                       : remove head entry (ignored when empty)
//   flush                     : empty the FIFO; wins over push and pop
//   count                     : number of valid entries (0..BUF_DEPTH)
//   head_valid/instr/pc       : combinational view of the head, zero when empty
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [INSTR_W-1:0]             push_instr,
    input  logic [ADDR_W-1:0]              push_pc,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(BUF_DEPTH):0]     count,
    output logic                           head_valid,
    output logic [INSTR_W-1:0]             head_instr,
    output logic [ADDR_W-1:0]              head_pc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem [BUF_DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_eff;
    logic             pop_eff;

    // The fetch FSM never pushes into a full buffer, so push needs no full
    // check; pop is masked when empty so a stray pop cannot underflow.
    assign push_eff = push && !flush;
    assign pop_eff  = pop && (count_reg != '0) && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_eff) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop_eff)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage has no reset; contents are only visible through the
    // count-qualified head outputs.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            instr_mem[wr_ptr_reg] <= push_instr;
            pc_mem[wr_ptr_reg]    <= push_pc;
        end
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head_instr = head_valid ? instr_mem[rd_ptr_reg] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr_reg]    : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues single halfword reads to the
// memory-access controller, buffers returned instructions and hands them to
// the decoder with a valid/stall handshake. Taken branches flush the buffer
// and cause any in-flight read to be discarded.
// Ports:
//   clk, reset (async, active-low)
//   stall_mem2fetch_in       : controller busy with decoder, request not accepted
//   mem_output_valid_in      : read data valid on mem_data_in
//   mem_data_in              : returned instruction
//   branch_taken_in          : redirect request
//   branch_target_in         : redirect address (bit 0 is forced to 0)
//   stall_decoder2fetch_in   : decoder cannot take instr_out this cycle
//   fetch_load_out/addr_out  : read request and address to the controller
//   instr_out/instr_pc_out   : buffer head instruction and its address
//   instr_valid_out          : buffer non-empty
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_mem2fetch_in,
    input  logic               mem_output_valid_in,
    input  logic [INSTR_W-1:0] mem_data_in,
    input  logic               branch_taken_in,
    input  logic [ADDR_W-1:0]  branch_target_in,
    input  logic               stall_decoder2fetch_in,
    output logic               fetch_load_out,
    output logic [ADDR_W-1:0]  fetch_addr_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc_out,
    output logic               instr_valid_out
);

    localparam int                CNT_W      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              push;
    logic              pop;
    logic              flush;
    logic              issue_req;
    logic [CNT_W-1:0]  count;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        issue_req  = 1'b0;
        flush      = branch_taken_in;
        pop        = instr_valid_out && !stall_decoder2fetch_in && !branch_taken_in;

        if (branch_taken_in) begin
            pc_next = branch_target_in & ALIGN_MASK;
            // A read accepted before the branch is still owed to us; its
            // data must be swallowed before a new request may go out.
            case (state_reg)
                ST_WAIT_DATA,
                ST_DISCARD:   state_next = ST_DISCARD;
                default:      state_next = ST_ISSUE;
            endcase
        end else begin
            case (state_reg)
                ST_ISSUE: begin
                    // reset gating keeps the request low while reset is held,
                    // even though the FSM already sits in ST_ISSUE.
                    issue_req = reset && (count < DEPTH_CNT);
                    if (issue_req && !stall_mem2fetch_in)
                        state_next = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (mem_output_valid_in) begin
                        push       = 1'b1;
                        pc_next    = pc_reg + ADDR_W'(HALFWORD_BYTES);
                        state_next = ST_ISSUE;
                    end
                end
                ST_DISCARD: begin
                    if (mem_output_valid_in)
                        state_next = ST_ISSUE;
                end
                default: state_next = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_ISSUE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // pc only advances when data is pushed, so during WAIT_DATA it still
    // equals the accepted address.
    assign fetch_load_out = issue_req;
    assign fetch_addr_out = pc_reg;

    fetch_buffer #(
        .ADDR_W    (ADDR_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_instr (mem_data_in),
        .push_pc    (pc_reg),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_valid (instr_valid_out),
        .head_instr (instr_out),
        .head_pc    (instr_pc_out)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall_mem2fetch_in;
    logic        mem_output_valid_in;
    logic [15:0] mem_data_in;
    logic        branch_taken_in;
    logic [15:0] branch_target_in;
    logic        stall_decoder2fetch_in;
    logic        fetch_load_out;
    logic [15:0] fetch_addr_out;
    logic [15:0] instr_out;
    logic [15:0] instr_pc_out;
    logic        instr_valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .ADDR_W    (16),
        .RESET_PC  (16'h0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall_mem2fetch_in     (stall_mem2fetch_in),
        .mem_output_valid_in    (mem_output_valid_in),
        .mem_data_in            (mem_data_in),
        .branch_taken_in        (branch_taken_in),
        .branch_target_in       (branch_target_in),
        .stall_decoder2fetch_in (stall_decoder2fetch_in),
        .fetch_load_out         (fetch_load_out),
        .fetch_addr_out         (fetch_addr_out),
        .instr_out              (instr_out),
        .instr_pc_out           (instr_pc_out),
        .instr_valid_out        (instr_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the DUT out of reset at a falling edge with the controller
    // stalled so no request is accepted until the caller drives inputs.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        stall_mem2fetch_in = 1'b1;
        mem_output_valid_in = 1'b0;
        mem_data_in = 16'h0000;
        branch_taken_in = 1'b0;
        branch_target_in = 16'h0000;
        stall_decoder2fetch_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; stall_mem2fetch_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL rst_load: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        if (instr_valid_out !== 1'b0) begin $display("FAIL rst_valid: got %0b want 0", instr_valid_out); n_fail++; end n_checks++;
        if (instr_out !== 16'h0000) begin $display("FAIL rst_instr: got %h want 0000", instr_out); n_fail++; end n_checks++;
        if (instr_pc_out !== 16'h0000) begin $display("FAIL rst_ipc: got %h want 0000", instr_pc_out); n_fail++; end n_checks++;
        if (fetch_addr_out !== 16'h0000) begin $display("FAIL rst_addr: got %h want 0000", fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        if (fetch_load_out !== 1'b1) begin $display("FAIL rst_rel_load: got %0b want 1", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL rst_wait_load: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        // reset in the middle of an outstanding read
        reset = 1'b0;
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL rst_mid_load: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        reset = 1'b1; stall_mem2fetch_in = 1'b1;
        mem_output_valid_in = 1'b1; mem_data_in = 16'hAAAA;
        #1;
        if (fetch_load_out !== 1'b1) begin $display("FAIL rst_late_load: got %0b want 1", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (instr_valid_out !== 1'b0) begin $display("FAIL rst_late_drop: got %0b want 0", instr_valid_out); n_fail++; end n_checks++;
        $display("test_reset done");
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        stall_mem2fetch_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0000) begin $display("FAIL basic_req0: got load=%0b addr=%h want 1/0000", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'h1111;
        #1;
        if (fetch_load_out !== 1'b0 || instr_valid_out !== 1'b0) begin $display("FAIL basic_wait0: got load=%0b valid=%0b want 0/0", fetch_load_out, instr_valid_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (instr_valid_out !== 1'b1 || instr_out !== 16'h1111 || instr_pc_out !== 16'h0000) begin $display("FAIL basic_instr0: got v=%0b %h@%h want 1 1111@0000", instr_valid_out, instr_out, instr_pc_out); n_fail++; end n_checks++;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0002) begin $display("FAIL basic_req1: got load=%0b addr=%h want 1/0002", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'h2222;
        #1;
        if (instr_valid_out !== 1'b0 || fetch_load_out !== 1'b0) begin $display("FAIL basic_wait1: got valid=%0b load=%0b want 0/0", instr_valid_out, fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b0; stall_mem2fetch_in = 1'b1;
        #1;
        if (instr_valid_out !== 1'b1 || instr_out !== 16'h2222 || instr_pc_out !== 16'h0002) begin $display("FAIL basic_instr1: got v=%0b %h@%h want 1 2222@0002", instr_valid_out, instr_out, instr_pc_out); n_fail++; end n_checks++;
        if (fetch_addr_out !== 16'h0004) begin $display("FAIL basic_addr2: got %h want 0004", fetch_addr_out); n_fail++; end n_checks++;
        $display("test_basic_fetch done");
    endtask

    task automatic test_mem_stall();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0000) begin $display("FAIL mstall_hold%0d: got load=%0b addr=%h want 1/0000", i, fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
            @(negedge clk);
        end
        stall_mem2fetch_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0000) begin $display("FAIL mstall_accept: got load=%0b addr=%h want 1/0000", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        stall_mem2fetch_in = 1'b1;
        mem_output_valid_in = 1'b1; mem_data_in = 16'h3333;
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL mstall_wait: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (instr_out !== 16'h3333 || instr_pc_out !== 16'h0000 || fetch_addr_out !== 16'h0002) begin $display("FAIL mstall_data: got %h@%h addr=%h want 3333@0000 0002", instr_out, instr_pc_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        #1;
        if (instr_valid_out !== 1'b0) begin $display("FAIL mstall_single: got valid=%0b want 0", instr_valid_out); n_fail++; end n_checks++;
        $display("test_mem_stall done");
    endtask

    task automatic test_decoder_stall();
        apply_reset();
        stall_decoder2fetch_in = 1'b1; stall_mem2fetch_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0000) begin $display("FAIL dstall_req0: got load=%0b addr=%h want 1/0000", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'hA001;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0002) begin $display("FAIL dstall_req1: got load=%0b addr=%h want 1/0002", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'hA002;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b0 || instr_out !== 16'hA001 || instr_pc_out !== 16'h0000) begin $display("FAIL dstall_full: got load=%0b %h@%h want 0 A001@0000", fetch_load_out, instr_out, instr_pc_out); n_fail++; end n_checks++;
        @(negedge clk);
        stall_decoder2fetch_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b0 || instr_valid_out !== 1'b1) begin $display("FAIL dstall_hold: got load=%0b valid=%0b want 0/1", fetch_load_out, instr_valid_out); n_fail++; end n_checks++;
        @(negedge clk);
        #1;
        if (instr_out !== 16'hA002 || instr_pc_out !== 16'h0002 || fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0004) begin $display("FAIL dstall_pop1: got %h@%h load=%0b addr=%h want A002@0002 1 0004", instr_out, instr_pc_out, fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        stall_mem2fetch_in = 1'b1;
        #1;
        if (instr_valid_out !== 1'b0 || fetch_load_out !== 1'b0) begin $display("FAIL dstall_pop2: got valid=%0b load=%0b want 0/0", instr_valid_out, fetch_load_out); n_fail++; end n_checks++;
        $display("test_decoder_stall done");
    endtask

    task automatic test_branch_wait();
        apply_reset();
        stall_mem2fetch_in = 1'b0;
        @(negedge clk);
        branch_taken_in = 1'b1; branch_target_in = 16'h0041;
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL brw_load: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        branch_taken_in = 1'b0;
        mem_output_valid_in = 1'b1; mem_data_in = 16'hDEAD;
        #1;
        if (fetch_load_out !== 1'b0 || instr_valid_out !== 1'b0) begin $display("FAIL brw_discard: got load=%0b valid=%0b want 0/0", fetch_load_out, instr_valid_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b0; stall_mem2fetch_in = 1'b1;
        #1;
        if (instr_valid_out !== 1'b0 || fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0040) begin $display("FAIL brw_redirect: got valid=%0b load=%0b addr=%h want 0 1 0040", instr_valid_out, fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        $display("test_branch_wait done");
    endtask

    task automatic test_branch_pop_push();
        apply_reset();
        stall_decoder2fetch_in = 1'b1; stall_mem2fetch_in = 1'b0;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'h1234;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        @(negedge clk);
        stall_decoder2fetch_in = 1'b0;
        mem_output_valid_in = 1'b1; mem_data_in = 16'h5678;
        branch_taken_in = 1'b1; branch_target_in = 16'h0100;
        #1;
        if (instr_valid_out !== 1'b1 || instr_out !== 16'h1234 || fetch_load_out !== 1'b0) begin $display("FAIL brp_pre: got v=%0b %h load=%0b want 1 1234 0", instr_valid_out, instr_out, fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        branch_taken_in = 1'b0; mem_output_valid_in = 1'b0; stall_mem2fetch_in = 1'b1;
        #1;
        if (instr_valid_out !== 1'b0 || instr_out !== 16'h0000 || instr_pc_out !== 16'h0000) begin $display("FAIL brp_flush: got v=%0b %h@%h want 0 0000@0000", instr_valid_out, instr_out, instr_pc_out); n_fail++; end n_checks++;
        if (fetch_load_out !== 1'b0 || fetch_addr_out !== 16'h0100) begin $display("FAIL brp_pc: got load=%0b addr=%h want 0 0100", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'hBAD0;
        @(negedge clk);
        mem_output_valid_in = 1'b0;
        #1;
        if (instr_valid_out !== 1'b0 || fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0100) begin $display("FAIL brp_resume: got v=%0b load=%0b addr=%h want 0 1 0100", instr_valid_out, fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        $display("test_branch_pop_push done");
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        stall_mem2fetch_in = 1'b0; stall_decoder2fetch_in = 1'b1;
        branch_taken_in = 1'b1; branch_target_in = 16'hFFFF;
        #1;
        if (fetch_load_out !== 1'b0) begin $display("FAIL wrap_brload: got %0b want 0", fetch_load_out); n_fail++; end n_checks++;
        @(negedge clk);
        branch_taken_in = 1'b0;
        #1;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'hFFFE) begin $display("FAIL wrap_req: got load=%0b addr=%h want 1 FFFE", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        @(negedge clk);
        mem_output_valid_in = 1'b1; mem_data_in = 16'hBEEF;
        @(negedge clk);
        mem_output_valid_in = 1'b0; stall_mem2fetch_in = 1'b1;
        #1;
        if (instr_out !== 16'hBEEF || instr_pc_out !== 16'hFFFE) begin $display("FAIL wrap_instr: got %h@%h want BEEF@FFFE", instr_out, instr_pc_out); n_fail++; end n_checks++;
        if (fetch_load_out !== 1'b1 || fetch_addr_out !== 16'h0000) begin $display("FAIL wrap_addr: got load=%0b addr=%h want 1 0000", fetch_load_out, fetch_addr_out); n_fail++; end n_checks++;
        $display("test_pc_wrap done");
    endtask

    initial begin
        reset = 1'b0;
        stall_mem2fetch_in = 1'b1;
        mem_output_valid_in = 1'b0;
        mem_data_in = 16'h0000;
        branch_taken_in = 1'b0;
        branch_target_in = 16'h0000;
        stall_decoder2fetch_in = 1'b0;
        test_reset();
        test_basic_fetch();
        test_mem_stall();
        test_decoder_stall();
        test_branch_wait();
        test_branch_pop_push();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction fetch stage directly upstream of the memory-access controller. Holds the PC and raises a fetch read request toward the controller, which arbitrates it against decoder loads/stores. Captures returned 16-bit instructions into a small FIFO and presents them to the decoder with a valid/stall handshake. Redirects on taken branches and discards any in-flight stale read.

Parameters:
ADDR_W, 16, width of PC and fetch address
RESET_PC, 0, PC value loaded at reset (bit 0 must be 0)
BUF_DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
stall_mem2fetch_in  in  1  controller grants the port to the decoder this cycle; fetch request not accepted
mem_output_valid_in  in  1  read data valid on mem_data_in
mem_data_in  in  16  read data (one halfword instruction)
branch_taken_in  in  1  redirect request from execute/decoder
branch_target_in  in  ADDR_W  redirect address
stall_decoder2fetch_in  in  1  decoder cannot accept instruction this cycle
fetch_load_out  out  1  fetch read request to controller
fetch_addr_out  out  ADDR_W  address of requested halfword
instr_out  out  16  FIFO head instruction
instr_pc_out  out  ADDR_W  address of instr_out
instr_valid_out  out  1  FIFO non-empty

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, FIFO empty, state=ISSUE; fetch_load_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, fetch_addr_out=RESET_PC.
- States: ISSUE, WAIT_DATA, DISCARD (2-bit encoded, one spare code -> ISSUE).
- ISSUE: fetch_load_out = (count < BUF_DEPTH) && !branch_taken_in; fetch_addr_out = pc. Request is accepted in the cycle fetch_load_out=1 and stall_mem2fetch_in=0 -> WAIT_DATA next cycle. If stall_mem2fetch_in=1, hold request and address stable; retry every cycle.
- WAIT_DATA: fetch_load_out=0, fetch_addr_out holds the accepted address. On mem_output_valid_in=1: push {mem_data_in, pc} into FIFO, pc <= pc+2 (mod 2^ADDR_W, wraps), -> ISSUE. Otherwise stay.
- DISCARD: fetch_load_out=0; on mem_output_valid_in=1 drop data, -> ISSUE.
- mem_output_valid_in is ignored in ISSUE (belongs to a decoder access).
- Branch (highest priority, any state): FIFO flushed (count=0), pc <= {branch_target_in[ADDR_W-1:1],1'b0}; ISSUE stays ISSUE; WAIT_DATA -> DISCARD without push even if valid arrives the same cycle; DISCARD stays DISCARD (one outstanding read only). fetch_load_out forced 0 in the branch cycle.
- Decoder handshake: instr_valid_out = count!=0; pop when instr_valid_out && !stall_decoder2fetch_in. instr_out/instr_pc_out combinationally show head; 0 when empty.
- Simultaneous push and pop: both occur, count unchanged. Flush beats pop and push in the same cycle.
- Issue gate guarantees a push never hits a full FIFO: request issued only if count<BUF_DEPTH and at most one read outstanding.
- Latency: request-to-instr_valid_out = memory latency + 1 cycle (registered push).
- Throughput: one instruction per (accept + data) round trip; no pipelined outstanding reads.
- Reset asserted mid-access: everything returns to reset values; a late mem_output_valid_in after release is treated as decoder data (ignored in ISSUE).

Decomposition:
- Shared package: fetch state encodings (ISSUE, WAIT_DATA, DISCARD), HALFWORD_BYTES=2, instruction width 16.
- One sub-module: fetch_buffer (synchronous FIFO, BUF_DEPTH x (16+ADDR_W), push/pop/flush, count, head outputs). FSM and PC stay in instruction_fetch.

Test Plan:
- Reset release, stall_mem2fetch_in=0, memory returns 0x1111,0x2222 after 1 cycle each -> fetch_addr_out 0x0000 then 0x0002; instr_out 0x1111@pc 0, then 0x2222@pc 2; valid 2 cycles after accept.
- stall_mem2fetch_in=1 for 3 cycles -> fetch_load_out=1 held, fetch_addr_out constant; accepted on 4th cycle, one read only.
- stall_decoder2fetch_in=1 permanently -> exactly BUF_DEPTH=2 pushes, then fetch_load_out=0; release -> pops one per cycle, fetching resumes.
- branch_taken_in (target 0x0041) during WAIT_DATA, data 0xDEAD returns next cycle -> 0xDEAD dropped, FIFO empty, next fetch_addr_out=0x0040.
- Branch same cycle as pop and mem_output_valid_in -> FIFO empty next cycle, no push, pc=target.
- pc=0xFFFE fetch completes -> pc wraps to 0x0000, next fetch_addr_out=0x0000.
